sort_sched: RTL and testbench

//   Shares one fixed-latency, non-stallable sort_top datapath between NREQ requesters.
//   - Round-robin arbitration among requesters.
//   - Credit-based per-requester result FIFOs, so no core output is ever lost.
//   - Returns each W-element result vector to the requester that issued the job.
//   - Sits between the requester front-ends and a single sort_top instance.
//

---
 rtl/sort_sched.sv | 140 ++++++++++++++
 tb/tb_sort_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_sched.sv
// Shares one fixed-latency sort_top core between NREQ requesters.
// Uses round-robin issue, credit flow control and per-requester result FIFOs.
module sort_sched #(
    parameter int NREQ  = 2,
    parameter int M     = 8,
    parameter int N     = 16,
    parameter int W     = 4,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ-1:0][M-1:0][N-1:0]    req_chi,
    output logic [M-1:0][N-1:0]              core_chi,
    input  logic [W-1:0][N-1:0]              core_y,
    output logic [NREQ-1:0]                  res_valid,
    input  logic [NREQ-1:0]                  res_ready,
    output logic [NREQ-1:0][W-1:0][N-1:0]    res_y,
    output logic                             busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    typedef logic [W-1:0][N-1:0] result_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           issue;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] wr_en;
    logic [CW-1:0]   credit [NREQ];
    logic [LAT:0]    tag_valid;
    logic [IDW-1:0]  tag_id [LAT+1];
    result_t         mem [NREQ][DEPTH];
    logic [PW-1:0]   wr_ptr [NREQ];
    logic [PW-1:0]   rd_ptr [NREQ];
    logic [PW:0]     count [NREQ];

    // A requester with no credit left has no FIFO room reserved, so it cannot compete
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            eligible[r] = req_valid[r] && (credit[r] != '0) && !rst;
        end
    end

    always_comb begin
        logic [IDW-1:0] cand;
        cand      = '0;
        issue     = 1'b0;
        grant     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!issue && eligible[cand]) begin
                issue = 1'b1;
                grant = cand;
            end
        end
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
    end

    // The tag pipe mirrors the core latency so each result can be routed home
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            core_chi  <= '0;
            tag_valid <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr   <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                core_chi <= req_chi[grant];
            end
            tag_valid <= {tag_valid[LAT-1:0], issue};
            tag_id[0] <= grant;
            for (int s = 1; s <= LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            res_valid[r] = (count[r] != '0);
            res_y[r]     = mem[r][rd_ptr[r]];
        end
    end

    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            pop[r]   = res_valid[r] && res_ready[r];
            wr_en[r] = tag_valid[LAT] && (tag_id[LAT] == IDW'(r));
        end
        busy = (|tag_valid) || (|res_valid);
    end

    // Credits reserve FIFO space at issue time, so a write never finds a full FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREQ; r++) begin
                credit[r] <= CW'(DEPTH);
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                count[r]  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem[r][d] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                case ({req_ready[r], pop[r]})
                    2'b10:   credit[r] <= credit[r] - 1'b1;
                    2'b01:   credit[r] <= credit[r] + 1'b1;
                    default: ;
                endcase
                if (wr_en[r]) begin
                    mem[r][wr_ptr[r]] <= core_y;
                    wr_ptr[r]         <= wr_ptr[r] + 1'b1;
                end
                if (pop[r]) begin
                    rd_ptr[r] <= rd_ptr[r] + 1'b1;
                end
                case ({wr_en[r], pop[r]})
                    2'b10:   count[r] <= count[r] + 1'b1;
                    2'b01:   count[r] <= count[r] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// Directed bench for sort_sched with a stub core that returns the W largest
// elements after LAT cycles.
module tb_sort_sched;
    localparam int NREQ  = 2;
    localparam int M     = 8;
    localparam int N     = 16;
    localparam int W     = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    typedef logic [M-1:0][N-1:0] chi_t;
    typedef logic [W-1:0][N-1:0] res_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NREQ-1:0]               req_valid;
    logic [NREQ-1:0]               req_ready;
    logic [NREQ-1:0][M-1:0][N-1:0] req_chi;
    chi_t                          core_chi;
    res_t                          core_y;
    logic [NREQ-1:0]               res_valid;
    logic [NREQ-1:0]               res_ready;
    logic [NREQ-1:0][W-1:0][N-1:0] res_y;
    logic                          busy;

    res_t stub_pipe [LAT];
    chi_t chi0, chi1, t1_chi;
    int   total = 0;
    int   bad   = 0;

    sort_sched #(
        .NREQ(NREQ), .M(M), .N(N), .W(W), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_chi(req_chi),
        .core_chi(core_chi), .core_y(core_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic res_t stub_sort(input chi_t chi);
        int   v [M];
        int   t;
        res_t y;
        for (int k = 0; k < M; k++) v[k] = int'(chi[k]);
        for (int a = 0; a < M; a++)
            for (int b = 0; b < M - 1 - a; b++)
                if (v[b] < v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        for (int k = 0; k < W; k++) y[W-1-k] = N'(v[k]);
        return y;
    endfunction

    always @(posedge clk) begin
        stub_pipe[0] <= stub_sort(core_chi);
        for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
    assign core_y = stub_pipe[LAT-1];

    function automatic chi_t mk_chi(input logic [N-1:0] base);
        chi_t c;
        for (int k = 0; k < M; k++) c[k] = base + N'(k);
        return c;
    endfunction

    // Elements of mk_chi(base) are base..base+7, so the top four are base+7..base+4
    function automatic res_t exp_top(input logic [N-1:0] base);
        return {base + 16'd7, base + 16'd6, base + 16'd5, base + 16'd4};
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        @(negedge clk);
        req_valid  = v;
        res_ready  = rr;
        req_chi[0] = chi0;
        req_chi[1] = chi1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  k, a0, a1;
        logic any, got;
        req_valid = '0;
        res_ready = '0;
        req_chi   = '0;
        chi0      = '0;
        chi1      = '0;

        // Reset: outputs quiet even with both requesters valid
        repeat (2) @(negedge clk);
        applyStimulus(2'b11, 2'b00);
        checkOutput("rst_req_ready", req_ready, 2'b00);
        checkOutput("rst_core_chi", core_chi, '0);
        checkOutput("rst_res_valid", res_valid, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;

        // Single job with fixed result latency
        t1_chi = {16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5};
        chi0 = t1_chi;
        applyStimulus(2'b01, 2'b00);
        checkOutput("t1_accept", req_ready, 2'b01);
        applyStimulus(2'b00, 2'b00);
        checkOutput("t1_core_chi", core_chi, t1_chi);
        checkOutput("t1_busy", busy, 1'b1);
        repeat (4) applyStimulus(2'b00, 2'b00);
        checkOutput("t1_not_early", res_valid, 2'b00);
        applyStimulus(2'b00, 2'b01);
        checkOutput("t1_res_valid", res_valid, 2'b01);
        checkOutput("t1_res_y", res_y[0], {16'd9, 16'd8, 16'd7, 16'd6});
        applyStimulus(2'b00, 2'b00);
        checkOutput("t1_popped", res_valid, 2'b00);
        checkOutput("t1_idle", busy, 1'b0);

        // Round-robin: pointer sits at 1 after the r0 job
        chi0 = mk_chi(16'h0200);
        chi1 = mk_chi(16'h0100);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t2_grant_a", req_ready, 2'b10);
        chi1 = mk_chi(16'h0110);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t2_grant_b", req_ready, 2'b01);
        chi0 = mk_chi(16'h0210);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t2_grant_c", req_ready, 2'b10);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t2_grant_d", req_ready, 2'b01);
        repeat (5) applyStimulus(2'b00, 2'b00);
        applyStimulus(2'b00, 2'b11);
        checkOutput("t2_both_valid", res_valid, 2'b11);
        checkOutput("t2_r0_first", res_y[0], exp_top(16'h0200));
        checkOutput("t2_r1_first", res_y[1], exp_top(16'h0100));
        applyStimulus(2'b00, 2'b11);
        checkOutput("t2_r0_second", res_y[0], exp_top(16'h0210));
        checkOutput("t2_r1_second", res_y[1], exp_top(16'h0110));
        applyStimulus(2'b00, 2'b00);
        checkOutput("t2_drained", {busy, res_valid}, 3'b000);

        // Credit backpressure on r0
        chi0 = mk_chi(16'h0300);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(2'b01, 2'b00);
            checkOutput("t3_credit_gate", req_ready, (c < 4) ? 2'b01 : 2'b00);
            if (c < 4) chi0 = mk_chi(16'h0300 + 16'(16 * (c + 1)));
        end
        applyStimulus(2'b01, 2'b01);
        checkOutput("t3_head", res_y[0], exp_top(16'h0300));
        checkOutput("t3_still_gated", req_ready, 2'b00);
        applyStimulus(2'b01, 2'b00);
        checkOutput("t3_reaccept", req_ready, 2'b01);
        chi0 = mk_chi(16'h0350);
        applyStimulus(2'b01, 2'b00);
        checkOutput("t3_regate", req_ready, 2'b00);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'b00, 2'b01);
            if (res_valid[0] && k < 8) begin
                checkOutput("t3_order", res_y[0], exp_top(16'h0310 + 16'(16 * k)));
                k++;
            end
        end
        checkOutput("t3_count", k, 4);

        // Issue and pop on r1 in the same cycle with one credit left
        chi1 = mk_chi(16'h0400);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(2'b10, 2'b00);
            checkOutput("t4_fill", req_ready, 2'b10);
            chi1 = mk_chi(16'h0400 + 16'(16 * (b + 1)));
        end
        repeat (7) applyStimulus(2'b00, 2'b00);
        checkOutput("t4_queued", res_valid, 2'b10);
        applyStimulus(2'b10, 2'b10);
        checkOutput("t4_issue_pop", req_ready, 2'b10);
        checkOutput("t4_pop_head", res_y[1], exp_top(16'h0400));
        chi1 = mk_chi(16'h0440);
        applyStimulus(2'b10, 2'b00);
        checkOutput("t4_credit_kept", req_ready, 2'b10);
        chi1 = mk_chi(16'h0450);
        applyStimulus(2'b10, 2'b00);
        checkOutput("t4_credit_zero", req_ready, 2'b00);
        repeat (3) applyStimulus(2'b00, 2'b00);
        k = 0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(2'b00, 2'b10);
            if (res_valid[1] && k < 8) begin
                checkOutput("t4_order", res_y[1], exp_top(16'h0410 + 16'(16 * k)));
                k++;
            end
        end
        checkOutput("t4_count", k, 4);
        checkOutput("t4_drained", {busy, res_valid}, 3'b000);

        // Reset with two results queued and three jobs in flight
        chi1 = mk_chi(16'h0500);
        applyStimulus(2'b10, 2'b00);
        chi1 = mk_chi(16'h0510);
        applyStimulus(2'b10, 2'b00);
        repeat (6) applyStimulus(2'b00, 2'b00);
        checkOutput("t5_queued", res_valid, 2'b10);
        chi0 = mk_chi(16'h0600);
        chi1 = mk_chi(16'h0520);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t5_grant_a", req_ready, 2'b01);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t5_grant_b", req_ready, 2'b10);
        applyStimulus(2'b11, 2'b00);
        checkOutput("t5_grant_c", req_ready, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_res_valid", res_valid, 2'b00);
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_ready", req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        any = 1'b0;
        repeat (10) begin
            applyStimulus(2'b00, 2'b00);
            any = any | (|res_valid) | busy;
        end
        checkOutput("t5_no_stale", any, 1'b0);
        a0 = 0;
        a1 = 0;
        repeat (10) begin
            applyStimulus(2'b11, 2'b00);
            if (req_ready[0]) a0++;
            if (req_ready[1]) a1++;
        end
        checkOutput("t5_credit_r0", a0, DEPTH);
        checkOutput("t5_credit_r1", a1, DEPTH);
        k = 0;
        repeat (40) begin
            applyStimulus(2'b00, 2'b11);
            k = k + int'(res_valid[0]) + int'(res_valid[1]);
        end
        checkOutput("t5_drain_count", k, 2 * DEPTH);

        // Starvation: r1 raises valid while r0 keeps requesting
        chi0 = mk_chi(16'h0700);
        chi1 = mk_chi(16'h0800);
        repeat (3) begin
            applyStimulus(2'b01, 2'b11);
            checkOutput("t6_r0_only", req_ready, 2'b01);
        end
        got = 1'b0;
        for (int c = 0; c < NREQ && !got; c++) begin
            applyStimulus(2'b11, 2'b11);
            if (req_ready[1]) got = 1'b1;
        end
        checkOutput("t6_r1_within_nreq", got, 1'b1);
        applyStimulus(2'b01, 2'b11);
        checkOutput("t6_back_to_r0", req_ready, 2'b01);
        repeat (12) applyStimulus(2'b00, 2'b11);
        checkOutput("t6_idle", {busy, res_valid}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
